// File: rtl/fft_r22sdf_twiddle.sv
// fft_r22sdf_twiddle: twiddle multiplier that follows one R2^2 SDF stage.
// Four-stage pipeline: ROM address, ROM read, partial products, round/sat.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_n          synchronous active-low reset
//   cnt_i          sample counter from the upstream butterfly
//   x_re_i/x_im_i  signed complex input sample
//   cnt_o          cnt_i delayed by 4 cycles
//   z_re_o/z_im_o  signed twiddle-multiplied sample, 4 cycles later
module fft_r22sdf_twiddle #(
  parameter int DATA_WIDTH = 25,
  parameter int TW_WIDTH   = 18,
  parameter int FFT_N      = 1024,
  parameter int FFT_NLOG2  = 10,
  parameter int STAGE      = 0,
  parameter int STAGES     = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_n,
  input  logic [FFT_NLOG2-1:0]        cnt_i,
  input  logic signed [DATA_WIDTH-1:0] x_re_i,
  input  logic signed [DATA_WIDTH-1:0] x_im_i,
  output logic [FFT_NLOG2-1:0]        cnt_o,
  output logic signed [DATA_WIDTH-1:0] z_re_o,
  output logic signed [DATA_WIDTH-1:0] z_im_o
);

  localparam int M  = FFT_NLOG2 - 2 * STAGE;
  localparam int PW = DATA_WIDTH + TW_WIDTH;
  localparam int SH = TW_WIDTH - 2;

  localparam logic signed [PW:0] ZMAX =
    {{(PW - DATA_WIDTH + 2){1'b0}},
     {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [PW:0] ZMIN = ~ZMAX;
  localparam logic signed [PW:0] RND =
    (PW + 1)'(1) << (SH - 1);

  localparam real PI = 3.14159265358979323846;
  localparam real SC = 1.0 * (1 << SH);

  // Twiddle ROM, built at elaboration
  logic signed [TW_WIDTH-1:0] rom_re [FFT_N];
  logic signed [TW_WIDTH-1:0] rom_im [FFT_N];

  for (genvar k = 0; k < FFT_N; k++) begin : g_rom
    localparam real AR = 2.0 * PI * k / FFT_N;
    localparam real CR = SC * $cos(AR);
    localparam real CI = -SC * $sin(AR);
    localparam int  WR = (CR < 0.0)
      ? -$rtoi(0.5 - CR) : $rtoi(CR + 0.5);
    localparam int  WI = (CI < 0.0)
      ? -$rtoi(0.5 - CI) : $rtoi(CI + 0.5);
    assign rom_re[k] = TW_WIDTH'(WR);
    assign rom_im[k] = TW_WIDTH'(WI);
  end

  // Twiddle index: rev2(top two local bits) * remaining bits
  logic [1:0]           t;
  logic [1:0]           t_rev;
  logic [M-1:0]         e;
  logic [FFT_NLOG2-1:0] addr_d;

  assign t = cnt_i[M-1:M-2];

  always_comb begin
    t_rev = t;
    unique case (t)
      2'b01:   t_rev = 2'b10;
      2'b10:   t_rev = 2'b01;
      default: t_rev = t;
    endcase
  end

  if (M > 2) begin : g_b
    assign e = M'(t_rev) * M'(cnt_i[M-3:0]);
  end else begin : g_nob
    assign e = '0;
  end

  // Later stages see a decimated twiddle set: scale by 4^STAGE
  assign addr_d = FFT_NLOG2'(e) << (2 * STAGE);

  // Pipeline registers
  logic signed [DATA_WIDTH-1:0] x1_re, x1_im;
  logic [FFT_NLOG2-1:0]         a1;
  logic signed [DATA_WIDTH-1:0] x2_re, x2_im;
  logic signed [TW_WIDTH-1:0]   w2_re, w2_im;
  logic signed [PW-1:0]         p_rr, p_ii, p_ri, p_ir;
  logic [FFT_NLOG2-1:0]         cnt_q [4];

  // Stage-4 combinational sum, round, shift
  logic signed [PW:0] s_re, s_im;
  logic signed [PW:0] r_re, r_im;

  always_comb begin
    s_re = (PW + 1)'(p_rr) - (PW + 1)'(p_ii);
    s_im = (PW + 1)'(p_ri) + (PW + 1)'(p_ir);
    r_re = (s_re + RND) >>> SH;
    r_im = (s_im + RND) >>> SH;
  end

  function automatic logic signed [DATA_WIDTH-1:0] sat(
    input logic signed [PW:0] v
  );
    if (v > ZMAX)
      return DATA_WIDTH'(ZMAX);
    else if (v < ZMIN)
      return DATA_WIDTH'(ZMIN);
    else
      return DATA_WIDTH'(v);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      x1_re  <= '0;
      x1_im  <= '0;
      a1     <= '0;
      x2_re  <= '0;
      x2_im  <= '0;
      w2_re  <= '0;
      w2_im  <= '0;
      p_rr   <= '0;
      p_ii   <= '0;
      p_ri   <= '0;
      p_ir   <= '0;
      z_re_o <= '0;
      z_im_o <= '0;
      for (int i = 0; i < 4; i++)
        cnt_q[i] <= '0;
    end else begin
      x1_re  <= x_re_i;
      x1_im  <= x_im_i;
      a1     <= addr_d;
      x2_re  <= x1_re;
      x2_im  <= x1_im;
      w2_re  <= rom_re[a1];
      w2_im  <= rom_im[a1];
      p_rr   <= PW'(x2_re) * PW'(w2_re);
      p_ii   <= PW'(x2_im) * PW'(w2_im);
      p_ri   <= PW'(x2_re) * PW'(w2_im);
      p_ir   <= PW'(x2_im) * PW'(w2_re);
      z_re_o <= sat(r_re);
      z_im_o <= sat(r_im);
      cnt_q[0] <= cnt_i;
      for (int i = 1; i < 4; i++)
        cnt_q[i] <= cnt_q[i-1];
    end
  end

  assign cnt_o = cnt_q[3];

endmodule

// File: tb/tb_fft_r22sdf_twiddle.sv
// tb_fft_r22sdf_twiddle: random + directed bench for the twiddle multiplier.
// A 4-entry delay-line model predicts every output cycle.
module tb_fft_r22sdf_twiddle;

  localparam int DW  = 25;
  localparam int TW  = 18;
  localparam int N   = 16;
  localparam int NL  = 4;
  localparam int STG = 0;
  localparam int M   = NL - 2 * STG;
  localparam int SH  = TW - 2;

  localparam real    PI   = 3.14159265358979323846;
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint MINV = -MAXV - 1;

  logic                 clk_i = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NL-1:0]        cnt_i = '0;
  logic [NL-1:0]        cnt_o;
  logic signed [DW-1:0] x_re_i = '0;
  logic signed [DW-1:0] x_im_i = '0;
  logic signed [DW-1:0] z_re_o;
  logic signed [DW-1:0] z_im_o;

  int n_chk  = 0;
  int n_pass = 0;

  fft_r22sdf_twiddle #(
    .DATA_WIDTH(DW),
    .TW_WIDTH  (TW),
    .FFT_N     (N),
    .FFT_NLOG2 (NL),
    .STAGE     (STG),
    .STAGES    (2)
  ) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .cnt_i (cnt_i),
    .x_re_i(x_re_i),
    .x_im_i(x_im_i),
    .cnt_o (cnt_o),
    .z_re_o(z_re_o),
    .z_im_o(z_im_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic longint rnd_away(input real r);
    if (r < 0.0) return -longint'($rtoi(0.5 - r));
    return longint'($rtoi(r + 0.5));
  endfunction

  function automatic longint tw_re(input int k);
    return rnd_away(real'(1 << SH) * $cos(2.0 * PI * k / N));
  endfunction

  function automatic longint tw_im(input int k);
    return rnd_away(-real'(1 << SH) * $sin(2.0 * PI * k / N));
  endfunction

  function automatic longint clip(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic void model(input int cnt, input longint xr,
                                input longint xi, output longint zr,
                                output longint zi);
    int c, t, b, e, k;
    longint wr, wi;
    c  = cnt % (1 << M);
    t  = c / (1 << (M - 2));
    b  = c % (1 << (M - 2));
    e  = ((t % 2) * 2 + t / 2) * b;
    k  = (e * (4 ** STG)) % N;
    wr = tw_re(k);
    wi = tw_im(k);
    zr = clip((xr * wr - xi * wi + (longint'(1) << (SH - 1))) >>> SH);
    zi = clip((xr * wi + xi * wr + (longint'(1) << (SH - 1))) >>> SH);
  endfunction

  typedef struct {
    bit     rst;
    int     c;
    longint xr;
    longint xi;
  } smp_t;

  smp_t   hq[$];
  smp_t   cur;
  bit     any_rst;
  bit     e_ok = 1'b0;
  longint e_re, e_im, e_cnt;

  // Expected output after each edge: zero if reset was seen at any of
  // the last four edges, otherwise f(input sampled three edges ago).
  always @(posedge clk_i) begin
    cur.rst = !rst_n;
    cur.c   = int'(cnt_i);
    cur.xr  = x_re_i;
    cur.xi  = x_im_i;
    hq.push_front(cur);
    if (hq.size() > 4) void'(hq.pop_back());
    any_rst = 1'b0;
    foreach (hq[i]) if (hq[i].rst) any_rst = 1'b1;
    if (any_rst) begin
      e_ok  = 1'b1;
      e_re  = 0;
      e_im  = 0;
      e_cnt = 0;
    end else if (hq.size() < 4) begin
      e_ok = 1'b0;
    end else begin
      e_ok  = 1'b1;
      e_cnt = hq[3].c;
      model(hq[3].c, hq[3].xr, hq[3].xi, e_re, e_im);
    end
  end

  always @(negedge clk_i) begin
    if (e_ok) begin
      chk("z_re", z_re_o, e_re);
      chk("z_im", z_im_o, e_im);
      chk("cnt_o", cnt_o, e_cnt);
    end
  end

  task automatic drive(input bit r, input int c, input longint xr,
                       input longint xi);
    rst_n  = !r;
    cnt_i  = NL'(c);
    x_re_i = DW'(xr);
    x_im_i = DW'(xi);
    @(negedge clk_i);
  endtask

  function automatic longint rx();
    case ($urandom_range(0, 7))
      0: return MAXV;
      1: return MINV;
      default:
        return longint'($urandom_range(0, (1 << DW) - 1)) - (MAXV + 1);
    endcase
  endfunction

  initial begin
    longint mr, mi;

    model(6, 1000, 0, mr, mi);
    chk("model_c6_re", mr, 0);
    chk("model_c6_im", mi, -1000);
    model(13, 65536, 0, mr, mi);
    chk("model_c13_re", mr, 25080);
    chk("model_c13_im", mi, -60547);
    model(5, MAXV, MAXV, mr, mi);
    chk("model_sat_re", mr, 16777215);
    chk("model_sat_im", mi, 0);
    model(2, -12345, 777, mr, mi);
    chk("model_k0_re", mr, -12345);
    chk("model_k0_im", mi, 777);

    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
    chk("reset_z_re", z_re_o, 0);
    chk("reset_z_im", z_im_o, 0);
    chk("reset_cnt", cnt_o, 0);

    drive(0, 6, 1000, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    chk("wj_re", z_re_o, 0);
    chk("wj_im", z_im_o, -1000);
    chk("wj_cnt", cnt_o, 6);

    for (int i = 0; i < 4; i++) drive(0, i, -12345, 777);
    chk("k0_re", z_re_o, -12345);
    chk("k0_im", z_im_o, 777);
    chk("k0_cnt", cnt_o, 0);

    drive(0, 13, 65536, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    chk("w3_re", z_re_o, 25080);
    chk("w3_im", z_im_o, -60547);
    chk("w3_cnt", cnt_o, 13);

    drive(0, 5, MAXV, MAXV);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    chk("sat_re", z_re_o, MAXV);
    chk("sat_im", z_im_o, 0);

    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) drive(0, i, rx(), rx());

    for (int i = 0; i < 8; i++) drive(0, i, rx(), rx());
    drive(1, 8, rx(), rx());
    chk("midrst_re", z_re_o, 0);
    chk("midrst_cnt", cnt_o, 0);
    for (int i = 9; i < 12; i++) drive(0, i, rx(), rx());
    chk("midrst_hold_re", z_re_o, 0);
    chk("midrst_hold_cnt", cnt_o, 0);
    for (int i = 12; i < 32; i++) drive(0, i % N, rx(), rx());

    for (int i = 0; i < 200; i++)
      drive(0, int'($urandom_range(0, N - 1)), rx(), rx());

    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
    @(posedge clk_i);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_r22sdf_twiddle.md
FFT_R22SDF_TWIDDLE -- requirements
Module: fft_r22sdf_twiddle

Interface
REQ-001 Parameter DATA_WIDTH, default 25, width of each signed real/imag sample.
REQ-002 Parameter TW_WIDTH, default 18, width of each signed twiddle component.
REQ-003 Parameter FFT_N, default 1024, transform length.
REQ-004 Parameter FFT_NLOG2, default 10, log2(FFT_N).
REQ-005 Parameter STAGE, default 0, index of the upstream butterfly stage this multiplier follows.
REQ-006 Parameter STAGES, default 5, total radix-2^2 stages.
REQ-007 clk_i  input  1  clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 cnt_i  input  FFT_NLOG2  sample counter from upstream butterfly stage, aligned with x_*_i.
REQ-010 x_re_i / x_im_i  input  DATA_WIDTH each  signed complex sample from upstream butterfly stage.
REQ-011 cnt_o  output  FFT_NLOG2  cnt_i delayed by LATENCY, aligned with z_*_o, feeds next stage.
REQ-012 z_re_o / z_im_o  output  DATA_WIDTH each  signed twiddle-multiplied sample, registered.

Function
REQ-013 Local index width M = FFT_NLOG2-2*STAGE; local count c = cnt_i[M-1:0]; T = c[M-1:M-2]; B = c[M-3:0] (empty, B=0, when M=2).
REQ-014 Exponent e = rev2(T)*B, where rev2 swaps the two bits of T (0->0, 1->2, 2->1, 3->3).
REQ-015 Twiddle index k = (e * 4^STAGE) mod FFT_N; twiddle W = exp(-j*2*pi*k/FFT_N).
REQ-016 Twiddle ROM holds FFT_N entries: wr[k] = round(2^(TW_WIDTH-2)*cos(2*pi*k/FFT_N)), wi[k] = round(-2^(TW_WIDTH-2)*sin(2*pi*k/FFT_N)), round half away from zero; contents fixed at elaboration.
REQ-017 Products full precision, DATA_WIDTH+TW_WIDTH bits: P_re = x_re*wr - x_im*wi; P_im = x_re*wi + x_im*wr.
REQ-018 Result = (P + 2^(TW_WIDTH-3)) arithmetic-shifted right by TW_WIDTH-2 (round half up).
REQ-019 Result saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; no wrap-around.
REQ-020 k=0 gives wr=2^(TW_WIDTH-2), wi=0; output equals input bit-exactly.
REQ-021 Pipeline: stage 1 registers x and ROM address; stage 2 registers ROM data and delayed x; stage 3 registers the four partial products; stage 4 registers the rounded, saturated sums to z_*_o.
REQ-022 LATENCY = 4 cycles from x_*_i/cnt_i to z_*_o/cnt_o; fixed, no stalls, one sample accepted every cycle.
REQ-023 cnt_o is a 4-deep shift-register copy of cnt_i; it is not recomputed.
REQ-024 No handshake: input is sampled every cycle; downstream qualifies data by cnt_o.
REQ-025 cnt_i wrapping from FFT_N-1 to 0 needs no special handling; the index is a pure function of cnt_i each cycle.

Reset
REQ-026 While rst_n=0 at a clock edge, all pipeline registers, z_re_o, z_im_o and cnt_o are cleared to 0 on that edge.
REQ-027 Reset mid-frame discards in-flight samples; outputs are 0 for the 4 cycles after rst_n returns to 1, then track input with LATENCY 4.
REQ-028 The ROM is not affected by reset.

Verification (FFT_N=16, FFT_NLOG2=4, STAGES=2, STAGE=0, DATA_WIDTH=25, TW_WIDTH=18)
REQ-029 cnt_i=6 (T=1, B=2, e=4, W=-j), x=(1000,0) -> 4 cycles later z=(0,-1000), cnt_o=6.
REQ-030 cnt_i=0..3 (e=0), x=(-12345,777) -> z equals x exactly, 4 cycles later for each sample.
REQ-031 cnt_i=13 (T=3, B=1, e=3, W16^3: wr=25080, wi=-60547), x=(65536,0) -> z=(25080,-60547).
REQ-032 Saturation: x=(2^24-1, 2^24-1), cnt_i=5 (e=2, W=(46341,-46341)) -> z_re=2^24-1 clipped, z_im=0.
REQ-033 Continuous cnt_i 0..15 twice, random x -> every output matches a bit-accurate model per REQ-014..019; cnt_o follows cnt_i with lag 4, including the 15->0 wrap.
REQ-034 rst_n low for 1 cycle mid-stream -> z_*_o and cnt_o are 0 on the next edge and for 4 cycles after release, then correct.
